// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: shifts per-pad configuration words into two daisy-chained
// strings of GPIO control blocks, then pulses a shared load strobe.
// Both chains shift in lock-step. The shorter chain is padded with leading zeros.
// Optional feature macro: GPIO_LOADER_CHAIN_RST_EN. When it is defined, each
// transfer begins with a serial_resetn pulse in a CHAIN_RST state.
//
// Handshake: start is sampled only while the block is idle (busy=0). A sampled
// start captures cfg_data and begins a transfer. busy rises on the next cycle.
// Any start seen while busy is dropped. done pulses for one cycle in the same
// cycle that busy falls.
module gpio_serial_loader #(
  parameter int AREA1PADS = 19,
  parameter int AREA2PADS = 19,
  parameter int CFG_BITS  = 13,
  parameter int CLK_DIV   = 2
) (
  input  logic                                       clock,
  input  logic                                       resetn,
  input  logic                                       start,
  input  logic [(AREA1PADS+AREA2PADS)*CFG_BITS-1:0]  cfg_data,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       serial_clock,
  output logic                                       serial_load,
  output logic                                       serial_resetn,
  output logic                                       serial_data_1,
  output logic                                       serial_data_2,
  output logic [1:0]                                 o_dbg_state
);

  localparam int MAX_PADS = (AREA1PADS > AREA2PADS) ? AREA1PADS : AREA2PADS;
  localparam int N        = MAX_PADS * CFG_BITS;
  localparam int L1       = AREA1PADS * CFG_BITS;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W    = $clog2(N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

`ifdef GPIO_LOADER_CHAIN_RST_EN
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SHIFT     = 2'd1,
    S_LOAD      = 2'd2,
    S_CHAIN_RST = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;
`endif

  state_t           r_state;
  logic [DIV_W-1:0] r_div;     // cycle within the current phase
  logic             r_half;    // 0: first phase of a bit/strobe, 1: second phase
  logic [BIT_W-1:0] r_bit;     // index of the bit currently on the wires
  logic [N-1:0]     r_sh1;     // chain 1 snapshot, next bit to send at MSB
  logic [N-1:0]     r_sh2;     // chain 2 snapshot, next bit to send at MSB
  logic             r_busy;
  logic             r_done;
  logic             r_sclk;
  logic             r_sload;
  logic             r_srstn;
  logic             r_sd1;
  logic             r_sd2;

  logic [N-1:0]     w_snap1;
  logic [N-1:0]     w_snap2;
  logic             w_phase_end;

  // Arrange cfg_data into send order. MSB goes out first, and any leading zero
  // pads sit at the top of the vector.
  // Chain 1 sends pad AREA1PADS-1 first, which matches the natural layout.
  // Chain 2 sends its lowest pad first, so its pads are reversed here.
  always_comb begin
    w_snap1         = '0;
    w_snap1[L1-1:0] = cfg_data[L1-1:0];
    w_snap2         = '0;
    for (int q = 0; q < AREA2PADS; q++) begin
      w_snap2[(AREA2PADS-1-q)*CFG_BITS +: CFG_BITS] = cfg_data[(AREA1PADS+q)*CFG_BITS +: CFG_BITS];
    end
  end

  assign w_phase_end = (r_div == DIV_LAST);

  // Main sequencer: phase timing, shift registers and all registered strobes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_half  <= 1'b0;
      r_bit   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sload <= 1'b0;
      r_srstn <= 1'b0;
      r_sd1   <= 1'b0;
      r_sd2   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_srstn <= 1'b1;
      if (r_state != S_IDLE) begin
        if (w_phase_end) begin
          r_div  <= '0;
          r_half <= ~r_half;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_div  <= '0;
            r_half <= 1'b0;
            r_bit  <= '0;
`ifdef GPIO_LOADER_CHAIN_RST_EN
            r_state <= S_CHAIN_RST;
            r_sh1   <= w_snap1;
            r_sh2   <= w_snap2;
            r_srstn <= 1'b0;
`else
            r_state <= S_SHIFT;
            r_sd1   <= w_snap1[N-1];
            r_sd2   <= w_snap2[N-1];
            r_sh1   <= w_snap1 << 1;
            r_sh2   <= w_snap2 << 1;
`endif
          end
        end
`ifdef GPIO_LOADER_CHAIN_RST_EN
        S_CHAIN_RST: begin
          if (!r_half && !w_phase_end) begin
            r_srstn <= 1'b0;
          end
          if (r_half && w_phase_end) begin
            r_state <= S_SHIFT;
            r_sd1   <= r_sh1[N-1];
            r_sd2   <= r_sh2[N-1];
            r_sh1   <= r_sh1 << 1;
            r_sh2   <= r_sh2 << 1;
          end
        end
`endif
        S_SHIFT: begin
          if (!r_half && w_phase_end) begin
            r_sclk <= 1'b1;
          end
          if (r_half && w_phase_end) begin
            r_sclk <= 1'b0;
            if (r_bit == BIT_LAST) begin
              r_state <= S_LOAD;
              r_sd1   <= 1'b0;
              r_sd2   <= 1'b0;
              r_sload <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_sd1 <= r_sh1[N-1];
              r_sd2 <= r_sh2[N-1];
              r_sh1 <= r_sh1 << 1;
              r_sh2 <= r_sh2 << 1;
            end
          end
        end
        S_LOAD: begin
          if (!r_half && w_phase_end) begin
            r_sload <= 1'b0;
          end
          if (r_half && w_phase_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign serial_clock  = r_sclk;
  assign serial_load   = r_sload;
  assign serial_resetn = r_srstn;
  assign serial_data_1 = r_sd1;
  assign serial_data_2 = r_sd2;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader. Two instances are tested side by side:
// dut_a uses the default parameters, and dut_b uses 3/2 pads with CLK_DIV=1.
// A receiver-level model captures bits on serial_clock rising edges.
// On serial_load it rebuilds the per-pad words and checks them against the
// words queued when start was issued.
`timescale 1ns/1ps
module tb_gpio_serial_loader;

  localparam int CB  = 13;
  localparam int W_A = 38 * CB;
  localparam int W_B = 5 * CB;
`ifdef GPIO_LOADER_CHAIN_RST_EN
  localparam int CRST = 1;
`else
  localparam int CRST = 0;
`endif

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start_a = 1'b0;
  logic           start_b = 1'b0;
  logic [W_A-1:0] cfg_a = '0;
  logic [W_B-1:0] cfg_b = '0;
  logic a_busy, a_done, a_sclk, a_sload, a_srstn, a_sd1, a_sd2;
  logic b_busy, b_done, b_sclk, b_sload, b_srstn, b_sd1, b_sd2;
  logic [1:0] a_dbg, b_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W_A-1:0] exp_q_a[$];
  logic [W_A-1:0] exp_q_b[$];

  int   busy_len[2], last_busy_len[2], done_cnt[2], ncap[2], rises[2];
  int   load_len[2], rel_cnt[2], first_rise[2];
  logic prev_busy[2], prev_sclk[2], prev_sload[2], prev_sd1[2], prev_sd2[2];
  logic cap1[2][256];
  logic cap2[2][256];

  gpio_serial_loader dut_a (
    .clock(clk), .resetn(rstn), .start(start_a), .cfg_data(cfg_a),
    .busy(a_busy), .done(a_done), .serial_clock(a_sclk), .serial_load(a_sload),
    .serial_resetn(a_srstn), .serial_data_1(a_sd1), .serial_data_2(a_sd2),
    .o_dbg_state(a_dbg)
  );

  gpio_serial_loader #(.AREA1PADS(3), .AREA2PADS(2), .CFG_BITS(13), .CLK_DIV(1)) dut_b (
    .clock(clk), .resetn(rstn), .start(start_b), .cfg_data(cfg_b),
    .busy(b_busy), .done(b_done), .serial_clock(b_sclk), .serial_load(b_sload),
    .serial_resetn(b_srstn), .serial_data_1(b_sd1), .serial_data_2(b_sd2),
    .o_dbg_state(b_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int cd_of(input int i); return (i == 0) ? 2 : 1;   endfunction
  function automatic int a1_of(input int i); return (i == 0) ? 19 : 3; endfunction
  function automatic int a2_of(input int i); return (i == 0) ? 19 : 2; endfunction
  function automatic int n_of(input int i);
    return ((a1_of(i) > a2_of(i)) ? a1_of(i) : a2_of(i)) * CB;
  endfunction

  task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [dut%0d] t=%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  // receiver model and per-cycle output rules for one instance
  task automatic mon(input int i, input logic bz, input logic dn, input logic sc,
                     input logic sl, input logic s1, input logic s2, input logic sr,
                     input logic [1:0] dbg);
    int cd, n, a1, a2, lead1, lead2, pad, ones;
    logic exp_sr;
    logic [12:0] w;
    logic [W_A-1:0] exp;
    cd = cd_of(i); n = n_of(i); a1 = a1_of(i); a2 = a2_of(i);
    if (!rstn) begin
      chk(i, "reset_outputs", {23'd0, dbg, bz, dn, sc, sl, s1, s2, sr}, 32'd0);
      ncap[i] = 0; busy_len[i] = 0; rel_cnt[i] = 0; load_len[i] = 0;
      prev_busy[i] = 0; prev_sclk[i] = 0; prev_sload[i] = 0; prev_sd1[i] = 0; prev_sd2[i] = 0;
      return;
    end
    rel_cnt[i]++;
    if (bz) busy_len[i] = prev_busy[i] ? busy_len[i] + 1 : 1;
    exp_sr = (rel_cnt[i] >= 2);
    if (CRST == 1 && bz && busy_len[i] >= 1 && busy_len[i] <= cd) exp_sr = 1'b0;
    chk(i, "serial_resetn", {31'd0, sr}, {31'd0, exp_sr});
    if (!bz) chk(i, "idle_quiet", {28'd0, sc, sl, s1, s2}, 32'd0);
    if (dn) begin
      done_cnt[i]++;
      chk(i, "done_at_busy_fall", {30'd0, prev_busy[i], bz}, 32'd2);
    end
    if (!bz && prev_busy[i]) begin
      chk(i, "done_with_fall", {31'd0, dn}, 32'd1);
      chk(i, "busy_len", busy_len[i], 2 * cd * (n + 1 + CRST));
      last_busy_len[i] = busy_len[i];
    end
    if (sc && !prev_sclk[i]) begin
      if (ncap[i] == 0) begin
        first_rise[i] = busy_len[i];
        chk(i, "first_rise", busy_len[i], cd * (1 + 2 * CRST) + 1);
      end
      chk(i, "data_stable", {30'd0, s1, s2}, {30'd0, prev_sd1[i], prev_sd2[i]});
      if (ncap[i] < 256) begin
        cap1[i][ncap[i]] = s1;
        cap2[i][ncap[i]] = s2;
      end
      ncap[i]++;
    end
    if (sl) begin
      chk(i, "load_quiet", {29'd0, sc, s1, s2}, 32'd0);
      load_len[i]++;
    end
    if (!sl && prev_sload[i]) begin
      chk(i, "load_len", load_len[i], cd);
      load_len[i] = 0;
    end
    if (sl && !prev_sload[i]) begin
      chk(i, "bit_count", ncap[i], n);
      rises[i] = ncap[i];
      if ((i == 0 ? exp_q_a.size() : exp_q_b.size()) == 0) begin
        chk(i, "exp_empty", 32'd1, 32'd0);
      end else begin
        exp = (i == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
        lead1 = n - a1 * CB;
        lead2 = n - a2 * CB;
        ones = 0;
        for (int k = 0; k < lead1; k++) ones += int'(cap1[i][k]);
        chk(i, "lead_zero_1", ones, 0);
        ones = 0;
        for (int k = 0; k < lead2; k++) ones += int'(cap2[i][k]);
        chk(i, "lead_zero_2", ones, 0);
        for (int k = 0; k < a1; k++) begin
          pad = a1 - 1 - k;
          w = '0;
          for (int b = 0; b < CB; b++) w = {w[11:0], cap1[i][lead1 + k * CB + b]};
          chk(i, $sformatf("chain1_pad%0d", pad), {19'd0, w}, {19'd0, exp[pad * CB +: CB]});
        end
        for (int k = 0; k < a2; k++) begin
          pad = a1 + k;
          w = '0;
          for (int b = 0; b < CB; b++) w = {w[11:0], cap2[i][lead2 + k * CB + b]};
          chk(i, $sformatf("chain2_pad%0d", pad), {19'd0, w}, {19'd0, exp[pad * CB +: CB]});
        end
      end
      ncap[i] = 0;
    end
    prev_busy[i] = bz; prev_sclk[i] = sc; prev_sload[i] = sl;
    prev_sd1[i] = s1; prev_sd2[i] = s2;
  endtask

  // compare process: every cycle, sampled on the falling edge
  always @(negedge clk) begin
    mon(0, a_busy, a_done, a_sclk, a_sload, a_sd1, a_sd2, a_srstn, a_dbg);
    mon(1, b_busy, b_done, b_sclk, b_sload, b_sd1, b_sd2, b_srstn, b_dbg);
  end

  // driver tasks
  task automatic fill_cfg(input int seed);
    for (int p = 0; p < 38; p++) cfg_a[p * CB +: CB] = 13'(p) ^ 13'h1A5A ^ 13'(seed);
    for (int p = 0; p < 5; p++)  cfg_b[p * CB +: CB] = 13'(p) ^ 13'h1A5A ^ 13'(seed);
  endtask

  task automatic pulse_start(input bit do_a, input bit do_b);
    @(posedge clk); #1;
    if (do_a) begin start_a = 1'b1; exp_q_a.push_back(cfg_a); end
    if (do_b) begin start_b = 1'b1; exp_q_b.push_back(W_A'(cfg_b)); end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int i, input int max_cyc);
    bit seen;
    seen = 0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clk);
      if ((i == 0) ? a_done : b_done) seen = 1;
    end
    if (!seen) chk(i, "done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; ncap[i] = 0; rises[i] = 0; first_rise[i] = 0; last_busy_len[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);

    // defaults + unequal chains: pad p = p ^ 1A5A
    fill_cfg(0);
    pulse_start(1, 1);
    wait_done(1, 200);
    #2;
    chk(1, "lit_busy_len", last_busy_len[1], (CRST == 1) ? 82 : 80);
    chk(1, "lit_rises", rises[1], 39);
    chk(1, "lit_first_rise", first_rise[1], (CRST == 1) ? 4 : 2);
    chk(1, "lit_chain2_bit13", {31'd0, cap2[1][13]}, 32'd1);
    chk(1, "lit_chain2_bit12", {31'd0, cap2[1][12]}, 32'd0);
    chk(1, "lit_chain1_bit0", {31'd0, cap1[1][0]}, 32'd1);
    wait_done(0, 1200);
    #2;
    chk(0, "lit_busy_len", last_busy_len[0], (CRST == 1) ? 996 : 992);
    chk(0, "lit_first_rise", first_rise[0], (CRST == 1) ? 7 : 3);
    chk(0, "lit_rises", rises[0], 247);

    // start and cfg change mid-transfer are ignored
    fill_cfg(5);
    pulse_start(1, 0);
    repeat (98) @(posedge clk);
    #1 start_a = 1'b1;
    fill_cfg(9);
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(0, 1200);
    repeat (5) @(negedge clk);
    chk(0, "no_queued_start", {31'd0, a_busy}, 32'd0);
    chk(0, "done_count_mid", done_cnt[0], 2);

    // reset in the middle of bit 50
    fill_cfg(3);
    pulse_start(1, 0);
    repeat (200) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk(0, "async_reset", {25'd0, a_busy, a_done, a_sclk, a_sload, a_sd1, a_sd2, a_srstn}, 32'd0);
    chk(1, "async_reset", {25'd0, b_busy, b_done, b_sclk, b_sload, b_sd1, b_sd2, b_srstn}, 32'd0);
    exp_q_a.delete();
    exp_q_b.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    chk(0, "no_done_on_abort", done_cnt[0], 2);
    fill_cfg(7);
    pulse_start(1, 0);
    wait_done(0, 1200);

    // start held high: back-to-back transfers on dut_b, then dut_a
    fill_cfg(11);
    exp_q_b.push_back(W_A'(cfg_b));
    exp_q_b.push_back(W_A'(cfg_b));
    @(posedge clk); #1 start_b = 1'b1;
    wait_done(1, 200);
    @(negedge clk);
    chk(1, "b2b_busy", {31'd0, b_busy}, 32'd1);
    @(posedge clk); #1 start_b = 1'b0;
    wait_done(1, 200);

    exp_q_a.push_back(cfg_a);
    exp_q_a.push_back(cfg_a);
    @(posedge clk); #1 start_a = 1'b1;
    wait_done(0, 1200);
    @(negedge clk);
    chk(0, "b2b_busy", {31'd0, a_busy}, 32'd1);
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(0, 1200);

    repeat (10) @(negedge clk);
    #2;
    chk(0, "done_total", done_cnt[0], 5);
    chk(1, "done_total", done_cnt[1], 3);
    chk(0, "exp_left", exp_q_a.size(), 0);
    chk(1, "exp_left", exp_q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_serial_loader.md
GPIO_SERIAL_LOADER -- requirements
Module: gpio_serial_loader

Interface
REQ-001 SHALL have parameter AREA1PADS, default 19: number of pads on chain 1 (pads 0..AREA1PADS-1).
REQ-002 SHALL have parameter AREA2PADS, default 19: number of pads on chain 2 (pads AREA1PADS..AREA1PADS+AREA2PADS-1).
REQ-003 SHALL have parameter CFG_BITS, default 13: configuration bits per pad.
REQ-004 SHALL have parameter CLK_DIV, default 2, legal range >=1: clock cycles per serial_clock phase.
REQ-005 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  request a full configuration transfer.
REQ-008 SHALL have port cfg_data  input  (AREA1PADS+AREA2PADS)*CFG_BITS  per-pad config words; pad p occupies bits [p*CFG_BITS +: CFG_BITS].
REQ-009 SHALL have port busy  output  1  transfer in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transfer completion.
REQ-011 SHALL have ports serial_clock, serial_load, serial_resetn  output  1 each  shared strobes to both chains of per-pad GPIO control blocks.
REQ-012 SHALL have ports serial_data_1, serial_data_2  output  1 each  chain 1 / chain 2 serial data.

Function
REQ-013 SHALL implement states IDLE, CHAIN_RST, SHIFT, LOAD; CHAIN_RST exists only per REQ-027.
REQ-014 In IDLE, start=1 SHALL snapshot cfg_data into an internal register and enter SHIFT (or CHAIN_RST) on the same edge; busy SHALL be 1 from the next cycle.
REQ-015 Changes on cfg_data after the snapshot edge SHALL NOT affect the transfer in progress.
REQ-016 start while busy=1 SHALL be ignored and SHALL NOT queue.
REQ-017 N = max(AREA1PADS,AREA2PADS)*CFG_BITS bits SHALL be shifted on both chains in lock-step.
REQ-018 Each bit SHALL hold serial_data_x stable for 2*CLK_DIV cycles: serial_clock 0 for the first CLK_DIV cycles, 1 for the last CLK_DIV cycles (receivers sample on serial_clock rising edge).
REQ-019 Chain 1 order: pad AREA1PADS-1 first, down to pad 0; within a pad, MSB first.
REQ-020 Chain 2 order: pad AREA1PADS first, up to pad AREA1PADS+AREA2PADS-1; within a pad, MSB first.
REQ-021 The shorter chain SHALL emit |AREA1PADS-AREA2PADS|*CFG_BITS leading 0 bits so its last real bit coincides with the longer chain's last bit.
REQ-022 After bit N, LOAD SHALL drive serial_load=1 for CLK_DIV cycles, then serial_load=0 for CLK_DIV cycles, serial_clock=0, serial_data_x=0 throughout LOAD.
REQ-023 On LOAD exit: IDLE, busy=0 and done=1 in the same cycle; done=0 next cycle; start in that cycle SHALL be accepted.
REQ-024 busy SHALL be 1 for exactly 2*CLK_DIV*(N+1) cycles (plus 2*CLK_DIV with REQ-027); serial_clock/serial_load/serial_data_x SHALL be 0 whenever busy=0.

Reset
REQ-025 resetn=0 SHALL immediately force IDLE, busy=0, done=0, serial_clock=0, serial_load=0, serial_data_1=0, serial_data_2=0, serial_resetn=0, counters and snapshot cleared, including mid-transfer.
REQ-026 serial_resetn SHALL go 1 on the first clock edge after resetn deasserts and stay 1 except per REQ-027; a transfer aborted by reset SHALL NOT produce done.

Configuration
REQ-027 Macro GPIO_LOADER_CHAIN_RST_EN: when defined, an accepted start SHALL enter CHAIN_RST, driving serial_resetn=0 for CLK_DIV cycles then 1 for CLK_DIV cycles before SHIFT; when undefined, CHAIN_RST SHALL be absent and serial_resetn behaves per REQ-026 only.

Verification
REQ-028 Defaults, cfg_data pad p = p ^ 13'h1A5A, start pulse -> both chains' captured words match per pad, busy high exactly 992 cycles, single done pulse.
REQ-029 AREA1PADS=3, AREA2PADS=2, CFG_BITS=13, CLK_DIV=1 -> chain 2 emits 13 leading zeros, 39 serial_clock rising edges, busy high 80 cycles.
REQ-030 start re-asserted at cycle 100 of a transfer and cfg_data changed -> ignored; captured data equals original snapshot; one done only.
REQ-031 resetn asserted at bit 50 of SHIFT -> all outputs 0 same cycle asynchronously, no done; new start after release completes a full correct transfer.
REQ-032 GPIO_LOADER_CHAIN_RST_EN defined, defaults -> serial_resetn low exactly 2 cycles after start acceptance, first serial_clock rise 4 cycles later than without macro, busy high 996 cycles.
REQ-033 start held high continuously -> back-to-back transfers, each done followed by busy=1 on the next cycle.
